// File: rtl/jt6295_mix.sv
// Sums CH time-multiplexed signed slot samples into one OW-bit sample per frame (cen).
// Publish lands on the edge that samples cen; no backpressure. JT6295_MIX_SAT_EN selects saturate vs wrap.
module jt6295_mix #(
    parameter int CH = 4,
    parameter int IW = 12,
    parameter int OW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          cen_ch,
    input  logic [IW-1:0] sound_in,
    input  logic [CH-1:0] ch_mask,
    output logic [OW-1:0] sound_out,
    output logic          sample_ok,
    output logic          clip,
    output logic [3:0]    slot
);
    localparam int AW = IW + 4;
    localparam logic [3:0] LAST = 4'(CH - 1);

    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] acc_base, smp_ext;
    logic [3:0]           slot_q, slot_d, slot_base;
    logic [15:0]          mask_ext;
    logic [OW-1:0]        sound_q, lim;
    logic                 clip_q, lim_clip;
    logic                 sample_ok_q;

    assign smp_ext  = {{4{sound_in[IW-1]}}, sound_in};
    assign mask_ext = 16'(ch_mask);

    // A coincident cen starts the new frame, so this cycle's sample becomes slot 0.
    assign acc_base  = cen ? '0 : acc_q;
    assign slot_base = cen ? '0 : slot_q;

    always_comb begin
        acc_d  = acc_base;
        slot_d = slot_base;
        if (cen_ch) begin
            if (!mask_ext[slot_base])
                acc_d = acc_base + smp_ext;
            slot_d = (slot_base == LAST) ? slot_base : slot_base + 4'd1;
        end
    end

    generate
        if (OW >= AW) begin : g_ext
            assign lim      = OW'(acc_q);
            assign lim_clip = 1'b0;
        end else begin : g_lim
            logic [AW-OW:0] hi;
            logic           in_range;
            assign hi       = acc_q[AW-1:OW-1];
            assign in_range = (&hi) | ~(|hi);
            assign lim_clip = ~in_range;
`ifdef JT6295_MIX_SAT_EN
            assign lim = in_range     ? acc_q[OW-1:0] :
                         acc_q[AW-1]  ? {1'b1, {(OW-1){1'b0}}} :
                                        {1'b0, {(OW-1){1'b1}}};
`else
            assign lim = acc_q[OW-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            slot_q      <= '0;
            sound_q     <= '0;
            clip_q      <= 1'b0;
            sample_ok_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            slot_q      <= slot_d;
            sample_ok_q <= cen;
            if (cen) begin
                sound_q <= lim;
                clip_q  <= lim_clip;
            end
        end
    end

    assign sound_out = sound_q;
    assign clip      = clip_q;
    assign sample_ok = sample_ok_q;
    assign slot      = slot_q;
endmodule

// File: doc/jt6295_mix.md
# jt6295_mix

Parametrised successor to the fixed four-voice accumulator in the jt6295 sound path. It sums a time-multiplexed stream of signed per-channel samples into one output sample per frame, with channel count, input width and output width as parameters. It adds a per-channel mute mask, a clip indicator and a sample-valid strobe. It sits between the ADPCM decoder output (one sample per channel slot) and the core's `sound` output, and is reused by multi-chip boards that chain several decoders into one mix.

## Interface
Parameters:
- `CH`, 4: channel slots per frame (1..16).
- `IW`, 12: signed input sample width.
- `OW`, 14: signed output sample width (OW ≥ IW).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cen`  in  1  frame strobe, one `clk` cycle wide, one per output sample.
- `cen_ch`  in  1  slot strobe, one `clk` cycle wide, CH per frame.
- `sound_in`  in  IW  signed sample for the current slot, valid when `cen_ch`=1.
- `ch_mask`  in  CH  bit n=1 mutes slot n; sampled on each `cen_ch`.
- `sound_out`  out  OW  signed mixed sample, held between frames.
- `sample_ok`  out  1  one-cycle pulse when `sound_out` updates.
- `clip`  out  1  1 if the last published sample was limited or wrapped; held with `sound_out`.
- `slot`  out  4  current slot index; debug and arbitration use.

## Operation
- Accumulator `acc` is signed, AW = IW + 4 bits wide. It cannot overflow for CH ≤ 16.
- `slot` counter runs 0..CH-1. It advances on each `cen_ch` and saturates at CH-1: extra strobes in a frame still add into `acc`, but `slot` stays at CH-1.
- On `cen_ch` (without `cen`): if `ch_mask[slot]`=0, then `acc ← acc + sext(sound_in)`; otherwise `acc` is unchanged. `slot ← slot+1`, saturating.
- On `cen` (frame boundary):
  - Publish: `sound_out ← limit(acc)`, `clip` set accordingly, `sample_ok` pulses.
  - Then `acc ← 0` and `slot ← 0`.
- `cen` and `cen_ch` in the same cycle:
  - The publish uses `acc` before this cycle's add.
  - The incoming sample is slot 0 of the new frame: `acc ← (masked by ch_mask[0]) ? 0 : sext(sound_in)`, and `slot ← 1`.
- Fewer than CH `cen_ch` in a frame: publish the partial sum; no error flag.
- `limit()` maps AW bits to OW bits:
  - If OW ≥ AW: sign-extend, and `clip` is 0.
  - Otherwise the behaviour is set by the macro (see Configuration).
- No scaling shift is applied; gain staging is upstream.

## Timing
- Reset values: `sound_out`=0, `clip`=0, `sample_ok`=0, `slot`=0, internal `acc`=0.
- `rst` has priority over `cen` and `cen_ch`. Reset mid-frame discards the partial sum and performs no publish.
- Adds are registered: `acc` reflects a `cen_ch` sample on the following `clk` edge.
- Publish latency: `sound_out`, `clip` and `sample_ok` change on the `clk` edge that samples `cen`=1. `sample_ok` is high for exactly that one following cycle.
- `sound_out` is stable for the entire interval between `sample_ok` pulses.
- `cen` and `cen_ch` are ignored unless high; no handshake back-pressure exists.
- `ch_mask` changes take effect at the next `cen_ch`. No frame-alignment of the mask.

## Configuration
- `JT6295_MIX_SAT_EN` defined:
  - `limit()` saturates: values above 2^(OW-1)-1 clamp to 2^(OW-1)-1, and values below -2^(OW-1) clamp to -2^(OW-1).
  - `clip`=1 when clamping occurred.
- `JT6295_MIX_SAT_EN` undefined:
  - `limit()` truncates to the low OW bits (two's-complement wrap).
  - `clip`=1 when the discarded upper bits are not all copies of bit OW-1 (wrap detected).
  - The published value is the wrapped value.
- In both builds, `clip` is 0 when OW ≥ AW.

## Test plan
- Reset: assert `rst` mid-frame after two adds of 100, then pulse `cen` → `sound_out`=0, `clip`=0, `sample_ok` is low in the reset cycles and pulses once after the `cen`.
- Basic sum (CH=4, IW=12, OW=14, mask=0): slot samples 100, -50, 7, 0, then `cen` → `sound_out`=57, `clip`=0, one `sample_ok` pulse.
- Mute: same stream with `ch_mask`=4'b0010 → `sound_out`=107.
- Saturation (OW=12, `JT6295_MIX_SAT_EN` defined): four slots of 2047 → `sound_out`=2047, `clip`=1. Four slots of -2048 → `sound_out`=-2048, `clip`=1.
- Wrap (OW=12, macro undefined): four slots of 2047 (sum 8188 = 0x1FFC) → `sound_out`=-4 (0xFFC), `clip`=1. Samples 1000, -1000, 5, 0 → `sound_out`=5, `clip`=0.
- Coincident strobes: frame of 10, 20, 30; then `cen` and `cen_ch` together with `sound_in`=40, followed by 1, 1, 1 and `cen` → first `sound_out`=60, second `sound_out`=43, `slot` reads 1 immediately after the coincident cycle.
